// File: rtl/coprocessor_io_pkg.sv
// Shared definitions for the coprocessor IO responder.
// Holds the response codes seen by the core, the responder FSM states,
// the register index map and the request-word field layout.
package coprocessor_io_pkg;

    localparam int REQ_W  = 15;   // full request word width
    localparam int IDX_W  = 14;   // register index field width
    localparam int WR_BIT = 14;   // write flag position in the request word

    typedef enum logic [2:0] {
        CTRL_IDLE     = 3'b000,
        CTRL_BUSY     = 3'b001,
        CTRL_DONE_OK  = 3'b010,
        CTRL_DONE_ERR = 3'b110
    } ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [IDX_W-1:0] IDX_SCRATCH_LO = 14'h0001;
    localparam logic [IDX_W-1:0] IDX_SCRATCH_HI = 14'h000F;
    localparam logic [IDX_W-1:0] IDX_CYCLE      = 14'h0010;
    localparam logic [IDX_W-1:0] IDX_REQCNT     = 14'h0011;
    localparam logic [IDX_W-1:0] IDX_LASTERR    = 14'h0012;

    // True when the index addresses one of the read/write scratch registers.
    function automatic logic is_scratch(input logic [IDX_W-1:0] idx);
        return (idx >= IDX_SCRATCH_LO) && (idx <= IDX_SCRATCH_HI);
    endfunction

endpackage

// File: rtl/cop_regbank.sv
// Register bank behind the coprocessor IO responder.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   rd_idx -> rd_data    - combinational read by register index
//   hit, ro              - index is mapped / index is read-only
//   wr_en, wr_idx, wr_data - one scratch write per cycle
//   ok_pulse             - one successful completion (REQCNT increment)
//   err_pulse, err_word  - one failed completion and its request word (LASTERR)
module cop_regbank
    import coprocessor_io_pkg::*;
#(
    parameter int N = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [N-1:0]     rd_data,
    output logic             hit,
    output logic             ro,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [N-1:0]     wr_data,
    input  logic             ok_pulse,
    input  logic             err_pulse,
    input  logic [REQ_W-1:0] err_word
);

    // Scratch index 1..15 is stored in slot 0..14.
    logic [N-1:0] scratch_r [0:14];
    logic [N-1:0] cycle_r;
    logic [N-1:0] reqcnt_r;
    logic [N-1:0] lasterr_r;
    logic [3:0]   rd_slot_s;
    logic [3:0]   wr_slot_s;

    assign rd_slot_s = rd_idx[3:0] - 4'd1;
    assign wr_slot_s = wr_idx[3:0] - 4'd1;

    // Combinational read decode with mapped/read-only flags.
    always_comb begin
        rd_data = {N{1'b0}};
        hit     = 1'b0;
        ro      = 1'b0;
        if (is_scratch(rd_idx)) begin
            rd_data = scratch_r[rd_slot_s];
            hit     = 1'b1;
        end else begin
            case (rd_idx)
                IDX_CYCLE: begin
                    rd_data = cycle_r;
                    hit     = 1'b1;
                    ro      = 1'b1;
                end
                IDX_REQCNT: begin
                    rd_data = reqcnt_r;
                    hit     = 1'b1;
                    ro      = 1'b1;
                end
                IDX_LASTERR: begin
                    rd_data = lasterr_r;
                    hit     = 1'b1;
                    ro      = 1'b1;
                end
                default: begin
                    rd_data = {N{1'b0}};
                    hit     = 1'b0;
                    ro      = 1'b0;
                end
            endcase
        end
    end

    // Scratch register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                scratch_r[i] <= {N{1'b0}};
            end
        end else if (wr_en && is_scratch(wr_idx)) begin
            scratch_r[wr_slot_s] <= wr_data;
        end
    end

    // Free-running cycle counter and completion status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_r   <= {N{1'b0}};
            reqcnt_r  <= {N{1'b0}};
            lasterr_r <= {N{1'b0}};
        end else begin
            cycle_r <= cycle_r + {{(N-1){1'b0}}, 1'b1};
            if (ok_pulse) begin
                reqcnt_r <= reqcnt_r + {{(N-1){1'b0}}, 1'b1};
            end
            if (err_pulse) begin
                lasterr_r <= {{(N-REQ_W){1'b0}}, err_word};
            end
        end
    end

endmodule

// File: rtl/coprocessor_io_responder.sv
// Coprocessor-side responder for the core's coprocessor IO port.
// Accepts a request word from IDLE, holds BUSY for LATENCY cycles, then
// presents DONE_OK / DONE_ERR with registered data until the core returns
// the request word to zero.
// Ports:
//   CLOCK_50, reset_n     - clock, asynchronous active-low reset
//   coprocessorIOAddr     - request word (bit 14 write, bits 13:0 index), 0 = idle
//   coprocessorIODataOut  - write data from the core
//   coprocessorIOControl  - registered response code
//   coprocessorIODataIn   - registered response data, valid in DONE_*
module coprocessor_io_responder #(
    parameter int N       = 64,
    parameter int LATENCY = 2
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic [14:0]   coprocessorIOAddr,
    input  logic [N-1:0]  coprocessorIODataOut,
    output logic [2:0]    coprocessorIOControl,
    output logic [N-1:0]  coprocessorIODataIn
);
    import coprocessor_io_pkg::*;

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    state_e           state_r;
    logic [3:0]       busy_cnt_r;
    logic [REQ_W-1:0] req_r;
    logic [N-1:0]     wdata_r;
    logic [N-1:0]     rdata_r;

    logic [REQ_W-1:0] cur_req_s;
    logic [N-1:0]     cur_wdata_s;
    logic [N-1:0]     rd_val_s;
    logic [N-1:0]     rd_data_s;
    logic             hit_s;
    logic             ro_s;
    logic             latch_s;
    logic             done_entry_s;
    logic             req_err_s;
    logic             ok_pulse_s;
    logic             err_pulse_s;
    logic             wr_en_s;
    logic [2:0]       resp_code_s;
    logic [N-1:0]     resp_data_s;

    // With LATENCY = 0 the request completes in its latch cycle, so the
    // live inputs stand in for the not-yet-loaded latches while in IDLE.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_req_s   = coprocessorIOAddr;
            cur_wdata_s = coprocessorIODataOut;
            rd_val_s    = rd_data_s;
        end else begin
            cur_req_s   = req_r;
            cur_wdata_s = wdata_r;
            rd_val_s    = rdata_r;
        end
    end

    assign latch_s      = (state_r == ST_IDLE) && (coprocessorIOAddr != 15'd0);
    assign done_entry_s = (latch_s && (LATENCY == 0)) ||
                          ((state_r == ST_BUSY) && (busy_cnt_r == LAT_CNT));
    assign ok_pulse_s   = done_entry_s && !req_err_s;
    assign err_pulse_s  = done_entry_s && req_err_s;
    assign wr_en_s      = ok_pulse_s && cur_req_s[WR_BIT];

    // Error classification and the response presented on DONE entry.
    // A REQCNT read reports the count including its own completion.
    always_comb begin
        req_err_s = !hit_s || (cur_req_s[WR_BIT] && ro_s);
        if (req_err_s) begin
            resp_code_s = CTRL_DONE_ERR;
            resp_data_s = {N{1'b0}};
        end else if (cur_req_s[WR_BIT]) begin
            resp_code_s = CTRL_DONE_OK;
            resp_data_s = cur_wdata_s;
        end else if (cur_req_s[IDX_W-1:0] == IDX_REQCNT) begin
            resp_code_s = CTRL_DONE_OK;
            resp_data_s = rd_val_s + {{(N-1){1'b0}}, 1'b1};
        end else begin
            resp_code_s = CTRL_DONE_OK;
            resp_data_s = rd_val_s;
        end
    end

    cop_regbank #(.N(N)) u_regbank (
        .clk       (CLOCK_50),
        .rst_n     (reset_n),
        .rd_idx    (cur_req_s[IDX_W-1:0]),
        .rd_data   (rd_data_s),
        .hit       (hit_s),
        .ro        (ro_s),
        .wr_en     (wr_en_s),
        .wr_idx    (cur_req_s[IDX_W-1:0]),
        .wr_data   (cur_wdata_s),
        .ok_pulse  (ok_pulse_s),
        .err_pulse (err_pulse_s),
        .err_word  (cur_req_s)
    );

    // Request FSM, latency counter, request latches and registered outputs.
    // Read data is captured at the latch cycle so CYCLE reports that cycle.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r              <= ST_IDLE;
            busy_cnt_r           <= 4'd0;
            req_r                <= 15'd0;
            wdata_r              <= {N{1'b0}};
            rdata_r              <= {N{1'b0}};
            coprocessorIOControl <= CTRL_IDLE;
            coprocessorIODataIn  <= {N{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (latch_s) begin
                        req_r   <= coprocessorIOAddr;
                        wdata_r <= coprocessorIODataOut;
                        rdata_r <= rd_data_s;
                        if (done_entry_s) begin
                            state_r              <= ST_DONE;
                            coprocessorIOControl <= resp_code_s;
                            coprocessorIODataIn  <= resp_data_s;
                        end else begin
                            state_r              <= ST_BUSY;
                            busy_cnt_r           <= 4'd1;
                            coprocessorIOControl <= CTRL_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (done_entry_s) begin
                        state_r              <= ST_DONE;
                        coprocessorIOControl <= resp_code_s;
                        coprocessorIODataIn  <= resp_data_s;
                    end else begin
                        busy_cnt_r <= busy_cnt_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    // Only a zero request word releases; anything else is ignored.
                    if (coprocessorIOAddr == 15'd0) begin
                        state_r              <= ST_IDLE;
                        coprocessorIOControl <= CTRL_IDLE;
                        coprocessorIODataIn  <= {N{1'b0}};
                    end
                end
                default: begin
                    state_r              <= ST_IDLE;
                    coprocessorIOControl <= CTRL_IDLE;
                    coprocessorIODataIn  <= {N{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coprocessor_io_responder.sv
// Self-checking bench for coprocessor_io_responder. Three instances run in
// parallel with LATENCY = 2, 0 and 15. Each has a driver that issues requests
// and pushes the reference model's expected response, and a monitor that
// pops and compares whenever the DUT enters DONE.
module tb_coprocessor_io_responder;

    typedef struct {
        logic [2:0]  c;
        logic [63:0] d;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 0 : 15);

        logic        rst  = 1'b0;
        logic [14:0] addr = 15'd0;
        logic [63:0] dout = 64'd0;
        logic [2:0]  ctrl;
        logic [63:0] din;
        bit          fin  = 1'b0;

        // reference state
        logic [63:0] scr [1:15];
        logic [63:0] reqcnt;
        logic [14:0] lasterr;
        logic [63:0] cyc;
        int          tick = 0;
        exp_t        q[$];

        logic        rel_pending;
        logic [2:0]  prev_ctrl = 3'd0;
        logic [63:0] prev_din  = 64'd0;

        coprocessor_io_responder #(.N(64), .LATENCY(LAT)) dut (
            .CLOCK_50            (clk),
            .reset_n             (rst),
            .coprocessorIOAddr   (addr),
            .coprocessorIODataOut(dout),
            .coprocessorIOControl(ctrl),
            .coprocessorIODataIn (din)
        );

        // reference cycle register: counts every non-reset edge
        always @(posedge clk or negedge rst) begin
            if (!rst) cyc <= 64'd0;
            else      cyc <= cyc + 64'd1;
        end

        always @(posedge clk) tick <= tick + 1;

        // core release seen by the responder at this edge (DONE and Addr == 0)
        always @(posedge clk or negedge rst) begin
            if (!rst) rel_pending <= 1'b0;
            else      rel_pending <= ctrl[1] && (addr == 15'd0);
        end

        // monitor
        always @(negedge clk) begin
            if (!rst) begin
                prev_ctrl <= 3'd0;
                prev_din  <= 64'd0;
            end else begin
                if (rel_pending) begin
                    chk($sformatf("L%0d release_ctrl", LAT), {61'd0, ctrl}, 64'd0);
                    chk($sformatf("L%0d release_data", LAT), din, 64'd0);
                end else if (ctrl[1] && !prev_ctrl[1]) begin
                    if (q.size() == 0) begin
                        chk($sformatf("L%0d unexpected_done", LAT), {61'd0, ctrl}, 64'd0);
                    end else begin
                        chk($sformatf("L%0d done_code", LAT), {61'd0, ctrl}, {61'd0, q[0].c});
                        chk($sformatf("L%0d done_data", LAT), din, q[0].d);
                        chk($sformatf("L%0d done_cycle", LAT), 64'(tick), 64'(q[0].due));
                        q.delete(0);
                    end
                end else if (ctrl[1]) begin
                    chk($sformatf("L%0d hold_ctrl", LAT), {61'd0, ctrl}, {61'd0, prev_ctrl});
                    chk($sformatf("L%0d hold_data", LAT), din, prev_din);
                end else if (ctrl == 3'd0) begin
                    chk($sformatf("L%0d idle_data", LAT), din, 64'd0);
                end
                prev_ctrl <= ctrl;
                prev_din  <= din;
            end
        end

        task automatic model_reset();
            for (int i = 1; i <= 15; i++) scr[i] = 64'd0;
            reqcnt  = 64'd0;
            lasterr = 15'd0;
        endtask

        // register-map semantics applied to one request
        task automatic model(input logic [14:0] a, input logic [63:0] d,
                             output logic [2:0] c, output logic [63:0] r);
            int idx;
            bit wr;
            bit ok;
            idx = int'(a[13:0]);
            wr  = a[14];
            ok  = 1'b1;
            r   = 64'd0;
            if (idx >= 1 && idx <= 15) begin
                if (wr) begin
                    scr[idx] = d;
                    r = d;
                end else begin
                    r = scr[idx];
                end
            end else if (idx == 16 && !wr) begin
                r = cyc;
            end else if (idx == 17 && !wr) begin
                r = reqcnt + 64'd1;
            end else if (idx == 18 && !wr) begin
                r = {49'd0, lasterr};
            end else begin
                ok = 1'b0;
            end
            if (ok) begin
                reqcnt = reqcnt + 64'd1;
                c = 3'b010;
            end else begin
                lasterr = a;
                c = 3'b110;
                r = 64'd0;
            end
        endtask

        task automatic req(input logic [14:0] a, input logic [63:0] d, input int hold, input bit mutate);
            exp_t e;
            int   n;
            @(posedge clk); #1;
            addr = a;
            dout = d;
            model(a, d, e.c, e.d);
            e.due = tick + 1 + LAT;
            q.push_back(e);
            if (mutate) begin
                @(posedge clk); #1;
                dout = ~d;
            end
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ctrl[1] && n < LAT + 8);
            chk($sformatf("L%0d done_seen", LAT), {63'd0, ctrl[1]}, 64'd1);
            if (hold > 0) begin
                addr = 15'h4007;   // must be ignored while in DONE
                repeat (hold) @(negedge clk);
            end
            @(posedge clk); #1;
            addr = 15'd0;
            dout = {$urandom, $urandom};
        endtask

        initial begin : driver
            logic [14:0] a;
            int          sel;
            exp_t        e;
            model_reset();
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk($sformatf("L%0d reset_ctrl", LAT), {61'd0, ctrl}, 64'd0);
                chk($sformatf("L%0d reset_data", LAT), din, 64'd0);
            end
            req(15'h0010, 64'd0, 0, 1'b0);
            req(15'h4005, 64'hDEADBEEF_CAFEF00D, 0, 1'b0);
            req(15'h0005, {$urandom, $urandom}, 0, 1'b0);
            req(15'h0011, 64'd0, 0, 1'b0);
            req(15'h4010, {$urandom, $urandom}, 0, 1'b0);
            req(15'h0123, 64'd0, 0, 1'b0);
            req(15'h0012, 64'd0, 0, 1'b0);
            req(15'h0010, 64'd0, 0, 1'b0);
            req(15'h4003, 64'h0123_4567_89AB_CDEF, 0, 1'b1);
            req(15'h0003, 64'h5555_AAAA_5555_AAAA, 5, 1'b1);
            req(15'h0011, 64'd0, 0, 1'b0);
            req(15'h0007, 64'd0, 0, 1'b0);
            req(15'h4000, 64'hFFFF_0000_FFFF_0000, 0, 1'b0);
            req(15'h0012, 64'd0, 0, 1'b0);

            // reset in the middle of a write to scratch 2
            @(posedge clk); #1;
            addr = 15'h4002;
            dout = 64'hA5A5_A5A5_A5A5_A5A5;
            model(addr, dout, e.c, e.d);
            @(posedge clk); #2;
            rst = 1'b0;
            #1;
            chk($sformatf("L%0d async_rst_ctrl", LAT), {61'd0, ctrl}, 64'd0);
            chk($sformatf("L%0d async_rst_data", LAT), din, 64'd0);
            q.delete();
            model_reset();
            addr = 15'd0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            req(15'h0002, 64'd0, 0, 1'b0);
            req(15'h0010, 64'd0, 0, 1'b0);

            for (int k = 0; k < 30; k++) begin
                sel = $urandom_range(0, 9);
                if (sel < 6)      a = {1'($urandom_range(0, 1)), 14'($urandom_range(1, 18))};
                else if (sel < 8) a = {1'b0, 14'($urandom_range(16, 18))};
                else              a = 15'($urandom);
                if (a == 15'd0) a = 15'h4000;
                req(a, {$urandom, $urandom}, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end
            repeat (2) @(negedge clk);
            chk($sformatf("L%0d queue_drained", LAT), 64'(q.size()), 64'd0);
            fin = 1'b1;
        end
    end

    initial begin : watchdog
        int i;
        i = 0;
        while (!(inst[0].fin && inst[1].fin && inst[2].fin) && i < 50000) begin
            @(posedge clk);
            i++;
        end
        chk("all_instances_finished",
            {61'd0, inst[0].fin, inst[1].fin, inst[2].fin}, 64'd7);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
